// File: rtl/inv_lift_pkg.sv
// Shared definitions for the inverse LeGall 5/3 lifting stage: state encoding,
// lifting constants and the final narrowing of reconstructed samples.
// Build option INV_LIFT_SAT_EN: when defined, narrow() saturates to the output
// range; when undefined, narrow() keeps the low bits (two's-complement wrap).
package inv_lift_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    EVEN,
    ODD,
    FL_EVEN,
    FL_ODD
  } inv_lift_state_t;

  // Rounding offset and shift of the update (even) step.
  localparam int ROUND_ADD  = 2;
  localparam int UPD_SHIFT  = 2;
  // Shift of the predict (odd) step.
  localparam int PRED_SHIFT = 1;

  // Working width of narrow(); comfortably wider than any DATA_W+GUARD_W in use.
  localparam int NARROW_W   = 64;

  // Bring a wide signed value into a dataW-bit signed range. The result is
  // returned sign-extended to NARROW_W so callers just keep the low dataW bits.
  function automatic logic signed [NARROW_W-1:0] narrow(
    input logic signed [NARROW_W-1:0] val,
    input int                         dataW
  );
`ifdef INV_LIFT_SAT_EN
    logic signed [NARROW_W-1:0] maxV;
    logic signed [NARROW_W-1:0] minV;
    maxV = (NARROW_W'(1) <<< (dataW - 1)) - NARROW_W'(1);
    minV = -maxV - NARROW_W'(1);
    if (val > maxV) begin
      return maxV;
    end
    if (val < minV) begin
      return minV;
    end
    return val;
`else
    return (val <<< (NARROW_W - dataW)) >>> (NARROW_W - dataW);
`endif
  endfunction

endpackage

// File: rtl/inverse_lifting_block_arith.sv
// Combinational lifting arithmetic of the inverse LeGall 5/3 stage.
// Given the incoming pair (s[n], d[n]) and the stored d[n-1], e[n-1], it
// produces the even sample e[n] and the odd sample o[n-1] of the previous pair.
// All intermediates are carried at DATA_W+GUARD_W bits; nothing is narrowed here.
module inv_lift_arith
  import inv_lift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int GUARD_W = 2
) (
  input  logic signed [DATA_W-1:0]         s_i,
  input  logic signed [DATA_W-1:0]         d_i,
  input  logic signed [DATA_W-1:0]         d_prev_i,
  input  logic signed [DATA_W+GUARD_W-1:0] e_prev_i,
  input  logic                             first_i,
  output logic signed [DATA_W+GUARD_W-1:0] e_cur_o,
  output logic signed [DATA_W+GUARD_W-1:0] o_prev_o
);

  localparam int W  = DATA_W + GUARD_W;
  localparam int WX = W + 1;

  logic signed [W-1:0]  dLeft;
  logic signed [W-1:0]  updSum;
  logic signed [W-1:0]  updTerm;
  logic signed [W-1:0]  eCur;
  logic signed [WX-1:0] predSum;
  logic signed [WX-1:0] predTerm;
  logic signed [W-1:0]  oPrev;

  // Update step: the first pair of a frame mirrors its own detail as d[-1].
  always_comb begin
    dLeft   = first_i ? W'(d_i) : W'(d_prev_i);
    updSum  = dLeft + W'(d_i) + W'(ROUND_ADD);
    updTerm = updSum >>> UPD_SHIFT;
    eCur    = W'(s_i) - updTerm;
  end

  // Predict step: odd sample of the previous pair from its detail and the evens on both sides.
  always_comb begin
    predSum  = WX'(e_prev_i) + WX'(eCur);
    predTerm = predSum >>> PRED_SHIFT;
    oPrev    = W'(d_prev_i) + W'(predTerm);
  end

  assign e_cur_o  = eCur;
  assign o_prev_o = oPrev;

endmodule

// File: rtl/inverse_lifting_block.sv
// Inverse (synthesis) integer LeGall 5/3 lifting stage of the ECG DWT chain.
// Accepts one (s[n], d[n]) coefficient pair per input handshake and emits the
// reconstructed samples x[0], x[1], ... one per output handshake, with out_last
// flagging the final sample of a frame.
// Build option INV_LIFT_SAT_EN: saturate x_out instead of wrapping it.
module inverse_lifting_block
  import inv_lift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int GUARD_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] s_in,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready
);

  localparam int W = DATA_W + GUARD_W;

  inv_lift_state_t          state_q;
  logic signed [DATA_W-1:0] d_q;
  logic signed [W-1:0]      e_q;
  logic signed [W-1:0]      odd_q;
  logic                     pend_last_q;
  logic                     in_ready_q;
  logic signed [DATA_W-1:0] x_q;
  logic                     out_valid_q;
  logic                     out_last_q;

  logic signed [W-1:0]      eCur;
  logic signed [W-1:0]      oPrev;
  logic signed [W-1:0]      flushOdd;
  logic signed [W-1:0]      xWide;
  logic signed [DATA_W-1:0] x_d;
  logic                     inFire;
  logic                     outFire;
  logic                     firstPair;

  assign inFire    = in_valid && in_ready_q;
  assign outFire   = out_valid_q && out_ready;
  assign firstPair = (state_q == IDLE);

  // At the end of a frame e[N] mirrors e[N-1], so the last odd is simply d + e.
  assign flushOdd  = W'(d_q) + e_q;

  inv_lift_arith #(
    .DATA_W  (DATA_W),
    .GUARD_W (GUARD_W)
  ) u_arith (
    .s_i      (s_in),
    .d_i      (d_in),
    .d_prev_i (d_q),
    .e_prev_i (e_q),
    .first_i  (firstPair),
    .e_cur_o  (eCur),
    .o_prev_o (oPrev)
  );

  // Select the full-width sample that x_out carries after the next transition, then narrow it.
  always_comb begin
    xWide = e_q;
    case (state_q)
      IDLE:    xWide = eCur;
      HOLD:    xWide = e_q;
      EVEN:    xWide = odd_q;
      ODD:     xWide = e_q;
      FL_EVEN: xWide = flushOdd;
      default: xWide = e_q;
    endcase
    x_d = DATA_W'(narrow(NARROW_W'(xWide), DATA_W));
  end

  // Frame sequencing: take pairs, then present even/odd samples and hold each until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      e_q         <= '0;
      odd_q       <= '0;
      pend_last_q <= 1'b0;
      in_ready_q  <= 1'b1;
      x_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inFire) begin
            d_q         <= d_in;
            e_q         <= eCur;
            pend_last_q <= 1'b0;
            if (in_last) begin
              x_q         <= x_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= FL_EVEN;
            end else begin
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (inFire) begin
            d_q         <= d_in;
            e_q         <= eCur;
            odd_q       <= oPrev;
            pend_last_q <= in_last;
            x_q         <= x_d;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= EVEN;
          end
        end
        EVEN: begin
          if (outFire) begin
            x_q     <= x_d;
            state_q <= ODD;
          end
        end
        ODD: begin
          if (outFire) begin
            if (pend_last_q) begin
              x_q     <= x_d;
              state_q <= FL_EVEN;
            end else begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        FL_EVEN: begin
          if (outFire) begin
            x_q        <= x_d;
            out_last_q <= 1'b1;
            state_q    <= FL_ODD;
          end
        end
        FL_ODD: begin
          if (outFire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            pend_last_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign x_out     = x_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_inverse_lifting_block.sv
// Self-checking bench for inverse_lifting_block. A frame-level model derives
// the expected sample stream from the lifting equations; one compare process
// checks every cycle the DUT presents a sample. A second 8-bit instance covers
// output narrowing (wrap, or saturation when INV_LIFT_SAT_EN is defined).
module tb_inverse_lifting_block;

  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] s_in;
  logic signed [DW-1:0] d_in;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic signed [DW-1:0] x_out;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready = 1'b1;

  logic signed [7:0]    s8;
  logic signed [7:0]    d8;
  logic                 in_valid8;
  logic                 in_last8;
  logic                 in_ready8;
  logic signed [7:0]    x8;
  logic                 out_valid8;
  logic                 out_last8;
  logic                 out_ready8;

  int     checks = 0;
  int     errors = 0;
  int     frameS [0:15];
  int     frameD [0:15];
  longint modelX [0:31];
  bit     modelL [0:31];
  longint expQ[$];
  bit     expLastQ[$];
  bit     checkEn = 1'b0;
  int     readyMode = 0;
  bit     manualReady = 1'b0;
  bit     gapEn = 1'b0;
  bit     pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int     patIdx = 0;
  int     cnt;

  always #5 clk = ~clk;

  inverse_lifting_block #(.DATA_W(DW), .GUARD_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  inverse_lifting_block #(.DATA_W(8), .GUARD_W(2)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s8),
    .d_in      (d8),
    .in_valid  (in_valid8),
    .in_last   (in_last8),
    .in_ready  (in_ready8),
    .x_out     (x8),
    .out_valid (out_valid8),
    .out_last  (out_last8),
    .out_ready (out_ready8)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reduce an exact value to a w-bit signed output the way the build option dictates.
  function automatic longint narrowBench(input longint v, input int w);
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
`ifdef INV_LIFT_SAT_EN
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
`else
    begin
      longint span;
      longint r;
      span = longint'(1) <<< w;
      r = v % span;
      if (r < 0) r = r + span;
      if (r > hi) r = r - span;
      return r;
    end
`endif
  endfunction

  // Whole-frame reconstruction from the lifting equations with exact integers.
  task automatic modelFrame(input int n, input int w);
    longint e [0:16];
    longint dl;
    longint o;
    for (int k = 0; k < n; k++) begin
      dl   = (k == 0) ? longint'(frameD[0]) : longint'(frameD[k-1]);
      e[k] = longint'(frameS[k]) - ((dl + longint'(frameD[k]) + 2) >>> 2);
    end
    e[n] = e[n-1];
    for (int k = 0; k < n; k++) begin
      o = longint'(frameD[k]) + ((e[k] + e[k+1]) >>> 1);
      modelX[2*k]   = narrowBench(e[k], w);
      modelL[2*k]   = 1'b0;
      modelX[2*k+1] = narrowBench(o, w);
      modelL[2*k+1] = (k == n - 1);
    end
  endtask

  // Queue the expected samples of the frame, then feed its pairs through the input handshake.
  task automatic applyStimulus(input int n, input bit keepValid);
    int waitCnt;
    modelFrame(n, DW);
    for (int k = 0; k < 2 * n; k++) begin
      expQ.push_back(modelX[k]);
      expLastQ.push_back(modelL[k]);
    end
    for (int k = 0; k < n; k++) begin
      if (gapEn && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_in     = frameS[k];
      d_in     = frameD[k];
      in_last  = (k == n - 1);
      in_valid = 1'b1;
      waitCnt  = 0;
      @(negedge clk);
      while (!in_ready && waitCnt < 200) begin
        @(negedge clk);
        waitCnt++;
      end
      if (!in_ready) checkOutput("in_ready timeout", longint'(in_ready), 1);
      @(posedge clk);
      #1;
    end
    if (!keepValid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int waitCnt;
    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 400) begin
      @(posedge clk);
      waitCnt++;
    end
    checkOutput("pending samples after drain", longint'(expQ.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Downstream readiness: always, random, the 1-0-0-1 pattern, or scripted.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        out_ready = pat[patIdx];
        patIdx    = (patIdx + 1) % 4;
      end
      default: out_ready = manualReady;
    endcase
  end

  // Compare every presented sample against the head of the expected stream.
  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      checkOutput("in_ready vs out_valid", longint'(in_ready), longint'(!out_valid));
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious out_valid", longint'(out_valid), 0);
        end else begin
          checkOutput("x_out", longint'(x_out), expQ[0]);
          checkOutput("out_last", longint'(out_last), longint'(expLastQ[0]));
          if (out_ready) begin
            void'(expQ.pop_front());
            void'(expLastQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not complete by t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    s_in       = '0;
    d_in       = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    s8         = '0;
    d8         = '0;
    in_valid8  = 1'b0;
    in_last8   = 1'b0;
    out_ready8 = 1'b0;
    #12;
    checkOutput("reset x_out", longint'(x_out), 0);
    checkOutput("reset out_valid", longint'(out_valid), 0);
    checkOutput("reset out_last", longint'(out_last), 0);
    checkOutput("reset in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    $display("[TB] basic two-pair frame");
    frameS[0] = 10; frameS[1] = 33; frameD[0] = 0; frameD[1] = 10;
    modelFrame(2, DW);
    checkOutput("model t1 x0", modelX[0], 10);
    checkOutput("model t1 x1", modelX[1], 20);
    checkOutput("model t1 x2", modelX[2], 30);
    checkOutput("model t1 x3", modelX[3], 40);
    checkOutput("model t1 last2", longint'(modelL[2]), 0);
    checkOutput("model t1 last3", longint'(modelL[3]), 1);
    applyStimulus(2, 1'b0);
    waitDrain();

    $display("[TB] single-pair frames");
    frameS[0] = 5; frameD[0] = 3;
    modelFrame(1, DW);
    checkOutput("model single x0", modelX[0], 3);
    checkOutput("model single x1", modelX[1], 6);
    applyStimulus(1, 1'b0);
    frameS[0] = -7; frameD[0] = -3;
    modelFrame(1, DW);
    checkOutput("model neg x0", modelX[0], -6);
    checkOutput("model neg x1", modelX[1], -9);
    applyStimulus(1, 1'b0);
    waitDrain();

    $display("[TB] stalled downstream");
    readyMode = 2;
    frameS[0] = 10; frameS[1] = 33; frameD[0] = 0; frameD[1] = 10;
    applyStimulus(2, 1'b0);
    waitDrain();
    readyMode = 0;

    $display("[TB] back-to-back frames");
    frameS[0] = 100; frameS[1] = 50; frameS[2] = -20;
    frameD[0] = 8;   frameD[1] = -4; frameD[2] = 6;
    applyStimulus(3, 1'b1);
    frameS[0] = 7; frameS[1] = 9; frameD[0] = -12; frameD[1] = 5;
    modelFrame(2, DW);
    checkOutput("model b2b x0", modelX[0], 13);
    checkOutput("model b2b x1", modelX[1], 0);
    checkOutput("model b2b x2", modelX[2], 11);
    checkOutput("model b2b x3", modelX[3], 16);
    applyStimulus(2, 1'b0);
    waitDrain();

    $display("[TB] randomized frames");
    gapEn     = 1'b1;
    readyMode = 1;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        if (f % 2 == 0) begin
          frameS[k] = int'($urandom_range(0, 32'h7FFF_FFFF)) - 32'sd1073741824;
          frameD[k] = int'($urandom_range(0, 32'h7FFF_FFFF)) - 32'sd1073741824;
        end else begin
          frameS[k] = int'($urandom());
          frameD[k] = int'($urandom());
        end
      end
      applyStimulus(n, 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitDrain();
    gapEn     = 1'b0;
    readyMode = 3;
    manualReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset during odd output");
    frameS[0] = 10; frameS[1] = 33; frameD[0] = 0; frameD[1] = 10;
    applyStimulus(2, 1'b0);
    #1 manualReady = 1'b1;
    @(posedge clk);
    #2 manualReady = 1'b0;
    @(posedge clk);
    #3;
    checkEn = 1'b0;
    checkOutput("odd before reset x_out", longint'(x_out), 20);
    checkOutput("odd before reset out_valid", longint'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid-frame reset x_out", longint'(x_out), 0);
    checkOutput("mid-frame reset out_valid", longint'(out_valid), 0);
    checkOutput("mid-frame reset out_last", longint'(out_last), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    expLastQ.delete();
    checkOutput("in_ready after reset", longint'(in_ready), 1);
    readyMode = 0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    applyStimulus(2, 1'b0);
    waitDrain();

    $display("[TB] 8-bit narrowing");
    frameS[0] = 127; frameD[0] = -128;
    modelFrame(1, 8);
`ifdef INV_LIFT_SAT_EN
    checkOutput("model w8 x0", modelX[0], 127);
`else
    checkOutput("model w8 x0", modelX[0], -65);
`endif
    checkOutput("model w8 x1", modelX[1], 63);
    s8        = 8'sd127;
    d8        = 8'h80;
    in_last8  = 1'b1;
    in_valid8 = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!in_ready8 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("w8 in_ready", longint'(in_ready8), 1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    in_last8  = 1'b0;
    @(negedge clk);
    checkOutput("w8 even valid", longint'(out_valid8), 1);
    checkOutput("w8 even x_out", longint'(x8), modelX[0]);
    checkOutput("w8 even out_last", longint'(out_last8), 0);
    out_ready8 = 1'b1;
    @(negedge clk);
    checkOutput("w8 odd valid", longint'(out_valid8), 1);
    checkOutput("w8 odd x_out", longint'(x8), modelX[1]);
    checkOutput("w8 odd out_last", longint'(out_last8), 1);
    @(negedge clk);
    checkOutput("w8 idle valid", longint'(out_valid8), 0);
    out_ready8 = 1'b0;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
